mp_add_seq: RTL and testbench
=============================

# mp_add_seq

Multi-precision add/subtract sequencer that time-shares a single `rc_adder16` ripple-carry adder across `WORDS` 16-bit words. An operand pair is accepted over a valid/ready handshake and processed one word per cycle, least-significant word first, with the carry registered between words. The result is held on a valid/ready output until it is consumed. The block sits between a host/register interface and the existing 16-bit adder datapath, giving wide arithmetic without replicating the adder.

## Interface
- `WIDTH`, default 16: adder word width. Fixed at 16 to match `rc_adder16`; any other value is a configuration error.
- `WORDS`, default 4: number of words per operand. Legal range is 2..16.
- `clk`  input  1: single clock. Every register updates on its rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `in_valid`  input  1: operand pair and op are valid.
- `in_ready`  output  1: the block can accept an operand pair.
- `a`  input  WIDTH*WORDS: operand A.
- `b`  input  WIDTH*WORDS: operand B.
- `carry_in`  input  1: initial carry for add. Ignored when `sub=1`.
- `sub`  input  1: 0 computes a+b+carry_in; 1 computes a-b, implemented as a+~b+1.
- `out_valid`  output  1: `sum` and `carry_out` are valid.
- `out_ready`  input  1: the consumer accepts the result.
- `sum`  output  WIDTH*WORDS: result, modulo 2^(WIDTH*WORDS).
- `carry_out`  output  1: final carry. When `sub=1`, 1 means no borrow (a>=b).

## Operation
- FSM states are IDLE, RUN and DONE. Reset sets state to IDLE, `sum`=0, `carry_out`=0, the word index to 0 and the carry register to 0.
- IDLE
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`:
    - Latch `a` into the A register.
    - Latch `b` into the B register, or `~b` when `sub=1`.
    - Carry register = (`sub` ? 1 : `carry_in`).
    - Index = 0, `sum` register cleared, go to RUN.
- RUN
  - The adder inputs are A word[idx], B word[idx] and the carry register.
  - Each cycle the adder sum is written into sum word[idx], the carry register takes the adder carry_out, and idx increments.
  - When idx==WORDS-1, `carry_out` is written from the adder, idx returns to 0 and the FSM goes to DONE.
- DONE
  - `out_valid`=1, with `sum`/`carry_out` stable.
  - On `out_ready`, go to IDLE.
- Inputs presented while `in_ready`=0 are ignored. There is no queuing.
- Index arithmetic is `$clog2(WORDS)` bits wide. The index never wraps inside RUN, because the FSM exits RUN at WORDS-1.
- `in_ready` is a pure decode of state==IDLE. It has no combinational path from `in_valid` or `out_ready`.

## Timing
- Acceptance edge E0. Word k is written at edge E(k+1). DONE is entered at edge E(WORDS), so `out_valid` rises WORDS cycles after acceptance (4 by default).
- If `out_ready` is already high in DONE, the result is consumed at the first DONE edge. `in_ready` is high in the following cycle.
- Minimum initiation interval is WORDS+2 cycles per operation.
- `sum` and `carry_out` change only during RUN and are stable throughout DONE. Partial words are visible during RUN but are not valid.
- `rst` asserted in any state, including mid-RUN, aborts the operation. At the next edge all outputs return to their reset values, state is IDLE, and no `out_valid` is produced.
- `rst` takes priority over a simultaneous `in_valid` or `out_ready`.

## Structure
- A shared package or include holds:
  - the state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the `WIDTH` constant (16)
- Exactly one sub-module: the existing `rc_adder16`, instantiated once.
- Word selection is done with indexed part-selects (`[idx*WIDTH +: WIDTH]`). There is no other sub-module.
- The remaining logic is the FSM, the A/B/sum registers, the index counter and the carry register.

## Test plan
- Reset behaviour: hold `rst`=1 for 3 cycles with `in_valid`=1 → `in_ready`=0 on no edge after reset releases, `out_valid`=0, `sum`=0, `carry_out`=0.
- All-ones add: a=b=64'hFFFF_FFFF_FFFF_FFFF, carry_in=0, sub=0 → `sum`=64'hFFFF_FFFF_FFFF_FFFE, `carry_out`=1, `out_valid` high exactly 4 cycles after acceptance.
- Carry ripple across words: a=64'h0000_0000_0000_FFFF, b=1, carry_in=1 → `sum`=64'h0000_0000_0001_0001, `carry_out`=0.
- Subtract with borrow: a=5, b=7, sub=1 → `sum`=64'hFFFF_FFFF_FFFF_FFFE, `carry_out`=0. Then a=7, b=5 → `sum`=2, `carry_out`=1.
- Output backpressure: hold `out_ready`=0 for 10 cycles in DONE → `sum` stable, `in_ready`=0, and a new `in_valid` is ignored. Raise `out_ready` → IDLE next cycle, and the next op is accepted one cycle later.
- Reset mid-operation: assert `rst` at the 2nd RUN cycle → next cycle IDLE, `sum`=0, no `out_valid`. A following add of 1+1 → `sum`=2.

Source files
------------

// File: rtl/mp_add_seq_pkg.sv
// Shared constants and state encoding for the multi-precision add/subtract sequencer.
// The word width is tied to the one adder that the sequencer time-shares.
package mp_add_seq_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MIN_WORDS  = 2;
    localparam int MAX_WORDS  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word index width. $clog2 alone would give 0 bits for a one-word build.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic bit words_legal(input int words);
        return (words >= MIN_WORDS) && (words <= MAX_WORDS);
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Operand request and result handshake between a host and mp_add_seq.
// The request and the result each use their own valid/ready pair.
interface mp_add_seq_if #(
    parameter int WORDS = 4
) ();
    import mp_add_seq_pkg::*;

    localparam int W = WORD_WIDTH * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    modport master (
        output in_valid,
        output a,
        output b,
        output carry_in,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  carry_in,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry_out
    );

endinterface

// File: rtl/rc_adder16.sv
// 16-bit ripple-carry adder: one full-adder cell per bit and a carry chain.
// The module is purely combinational.
module rc_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
        assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[16];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract that feeds one 16-bit ripple adder one word per cycle,
// least-significant word first, with the carry held in a register between words.
module mp_add_seq #(
    parameter int WIDTH = mp_add_seq_pkg::WORD_WIDTH,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    mp_add_seq_if.slave  bus
);
    import mp_add_seq_pkg::*;

    localparam int                W        = WIDTH * WORDS;
    localparam int                IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    // The adder is a fixed 16-bit block, so any other word width cannot be built.
    if ((WIDTH != WORD_WIDTH) || !words_legal(WORDS)) begin : g_bad_cfg
        $error("mp_add_seq: WIDTH must be 16 and WORDS must be within 2..16");
    end

    state_t            state_reg;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      sum_reg;
    logic              carry_out_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              carry_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;

    logic [WIDTH-1:0]  add_a;
    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

    assign add_a = a_reg[int'(idx_reg) * WIDTH +: WIDTH];
    assign add_b = b_reg[int'(idx_reg) * WIDTH +: WIDTH];

    rc_adder16 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Subtraction is folded in at acceptance time (B inverted, carry seeded with 1),
    // so the word loop below only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.sub ? ~bus.b : bus.b;
                        carry_reg    <= bus.sub ? 1'b1 : bus.carry_in;
                        idx_reg      <= '0;
                        sum_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end

                RUN: begin
                    sum_reg[int'(idx_reg) * WIDTH +: WIDTH] <= add_sum;
                    carry_reg <= add_cout;
                    if (idx_reg == LAST_IDX) begin
                        carry_out_reg <= add_cout;
                        idx_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    idx_reg       <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.carry_out = carry_out_reg;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: directed cases with literal results plus randomized traffic
// checked every cycle against a plain-arithmetic model of the handshake and result.
module tb_mp_add_seq;
    import mp_add_seq_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = WORD_WIDTH * WORDS;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   rand_rdy = 1'b0;

    mp_add_seq_if #(.WORDS(WORDS)) bus ();

    mp_add_seq #(.WIDTH(WORD_WIDTH), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Model: an op is outstanding from acceptance until consumption; the result
    // appears WORDS edges after the accepting edge and is then held.
    bit           m_busy   = 1'b0;
    int           m_n      = 0;
    logic [W-1:0] m_sum    = '0;
    logic         m_co     = 1'b0;
    logic [W-1:0] last_sum = '0;
    logic         last_co  = 1'b0;
    logic [W:0]   tmp;

    always @(negedge clk) begin
        check("in_ready", W'(bus.in_ready), W'(!m_busy));
        check("out_valid", W'(bus.out_valid), W'(m_busy && (m_n >= WORDS)));
        if (!m_busy) begin
            check("idle_sum", bus.sum, last_sum);
            check("idle_co", W'(bus.carry_out), W'(last_co));
        end else if (m_n >= WORDS) begin
            check("done_sum", bus.sum, m_sum);
            check("done_co", W'(bus.carry_out), W'(m_co));
        end

        if (rst) begin
            m_busy   = 1'b0;
            last_sum = '0;
            last_co  = 1'b0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy = 1'b1;
                m_n    = 0;
                if (bus.sub) begin
                    m_sum = bus.a - bus.b;
                    m_co  = (bus.a >= bus.b);
                end else begin
                    tmp   = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.carry_in);
                    m_sum = tmp[W-1:0];
                    m_co  = tmp[W];
                end
            end
        end else if ((m_n >= WORDS) && bus.out_ready) begin
            m_busy   = 1'b0;
            last_sum = m_sum;
            last_co  = m_co;
        end else begin
            m_n++;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #2;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
        bit ok = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", W'(ok), W'(1));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
    endtask

    task automatic wait_result(output logic [W-1:0] rs, output logic rc, output int lat);
        bit ok = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
        check("result_timeout", W'(ok), W'(1));
        rs = bus.sum;
        rc = bus.carry_out;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] r;
        for (int k = 0; k < WORDS; k++) begin
            case ($urandom_range(0, 3))
                0:       r[k*WORD_WIDTH +: WORD_WIDTH] = 16'hFFFF;
                1:       r[k*WORD_WIDTH +: WORD_WIDTH] = 16'h0000;
                default: r[k*WORD_WIDTH +: WORD_WIDTH] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    logic [W-1:0] ones;
    logic [W-1:0] msb;

    initial begin
        ones          = '1;
        msb           = '0;
        msb[W-1]      = 1'b1;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 64'd1;
        bus.b         = 64'd1;
        bus.carry_in  = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset held with in_valid asserted
        repeat (3) @(posedge clk);
        #2;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_sum", bus.sum, 64'h0);
        check("rst_co", W'(bus.carry_out), W'(0));
        @(posedge clk);
        #2;

        send(ones, ones, 1'b0, 1'b0);
        wait_result(rs, rc, lat);
        check("ones_sum", rs, 64'hFFFF_FFFF_FFFF_FFFE);
        check("ones_co", W'(rc), W'(1));
        check("ones_latency", W'(lat), W'(4));

        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 1'b0);
        wait_result(rs, rc, lat);
        check("ripple_sum", rs, 64'h0000_0000_0001_0001);
        check("ripple_co", W'(rc), W'(0));

        send(64'd5, 64'd7, 1'b0, 1'b1);
        wait_result(rs, rc, lat);
        check("sub_borrow_sum", rs, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_borrow_co", W'(rc), W'(0));

        send(64'd7, 64'd5, 1'b1, 1'b1);
        wait_result(rs, rc, lat);
        check("sub_sum", rs, 64'd2);
        check("sub_co", W'(rc), W'(1));

        send(64'd0, 64'd0, 1'b0, 1'b1);
        wait_result(rs, rc, lat);
        check("sub_zero_sum", rs, 64'd0);
        check("sub_zero_co", W'(rc), W'(1));

        send(msb, msb, 1'b0, 1'b0);
        wait_result(rs, rc, lat);
        check("msb_sum", rs, 64'd0);
        check("msb_co", W'(rc), W'(1));

        // Backpressure in DONE with a competing request
        bus.out_ready = 1'b0;
        send(64'd3, 64'd4, 1'b0, 1'b0);
        wait_result(rs, rc, lat);
        check("bp_sum", rs, 64'd7);
        bus.a        = 64'd100;
        bus.b        = 64'd200;
        bus.sub      = 1'b0;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_sum", bus.sum, 64'd7);
            check("bp_in_ready", W'(bus.in_ready), W'(0));
        end
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", W'(bus.in_ready), W'(1));
        check("bp_release_valid", W'(bus.out_valid), W'(0));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        wait_result(rs, rc, lat);
        check("bp_next_sum", rs, 64'd300);

        // Reset during the second RUN cycle
        send(64'd9, 64'd9, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", W'(bus.in_ready), W'(1));
        check("abort_out_valid", W'(bus.out_valid), W'(0));
        check("abort_sum", bus.sum, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        send(64'd1, 64'd1, 1'b0, 1'b0);
        wait_result(rs, rc, lat);
        check("after_abort_sum", rs, 64'd2);

        // Randomized traffic with random result backpressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
            send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_result(rs, rc, lat);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #3;
        bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
